// File: rtl/mor1kx_cfgrs_spr_slave_pkg.sv
// Shared definitions for the group-0 configuration SPR slave.
// Holds the SPR group-0 index constants (next to the OR1K SPR field layout)
// and the state encoding of the slave's access FSM.
package mor1kx_cfgrs_spr_slave_pkg;

   // SPR address layout: {group[15:11], index[10:0]}
   localparam int SPR_GROUP_MSB = 15;
   localparam int SPR_GROUP_LSB = 11;

   // Group-0 configuration register indices
   localparam logic [4:0] SPR_IDX_VR       = 5'd0;
   localparam logic [4:0] SPR_IDX_UPR      = 5'd1;
   localparam logic [4:0] SPR_IDX_CPUCFGR  = 5'd2;
   localparam logic [4:0] SPR_IDX_DMMUCFGR = 5'd3;
   localparam logic [4:0] SPR_IDX_IMMUCFGR = 5'd4;
   localparam logic [4:0] SPR_IDX_DCCFGR   = 5'd5;
   localparam logic [4:0] SPR_IDX_ICCFGR   = 5'd6;
   localparam logic [4:0] SPR_IDX_DCFGR    = 5'd7;
   localparam logic [4:0] SPR_IDX_PCCFGR   = 5'd8;
   localparam logic [4:0] SPR_IDX_VR2      = 5'd9;
   localparam logic [4:0] SPR_IDX_AVR      = 5'd10;

   // Reserved slot: a write here clears the write-error bookkeeping
   localparam logic [4:0] SPR_IDX_WERR_CLR = 5'd31;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_LOOKUP = 2'd1,
      ST_RESP   = 2'd2,
      ST_HOLD   = 2'd3
   } cfgrs_state_e;

endpackage

// File: rtl/mor1kx_cfgrs_spr_sel.sv
// Combinational index-to-value selector for the group-0 configuration SPRs.
// Indices above OPTION_CFGRS_MAX_INDEX, and any index without a register
// behind it, read as zero.
module mor1kx_cfgrs_spr_sel
   import mor1kx_cfgrs_spr_slave_pkg::*;
#(
   parameter int OPTION_CFGRS_MAX_INDEX = 10
)
(
   input  logic [4:0]  idx,
   input  logic [31:0] spr_vr,
   input  logic [31:0] spr_vr2,
   input  logic [31:0] spr_upr,
   input  logic [31:0] spr_cpucfgr,
   input  logic [31:0] spr_dmmucfgr,
   input  logic [31:0] spr_immucfgr,
   input  logic [31:0] spr_dccfgr,
   input  logic [31:0] spr_iccfgr,
   input  logic [31:0] spr_dcfgr,
   input  logic [31:0] spr_pccfgr,
   input  logic [31:0] spr_avr,
   output logic [31:0] dat
);

   localparam logic [4:0] MAX_IDX = 5'(OPTION_CFGRS_MAX_INDEX);

   // Pick the configuration word for the captured index, masked by the claimed window
   always_comb begin
      dat = 32'd0;
      if (idx > MAX_IDX) begin
         dat = 32'd0;
      end else begin
         case (idx)
            SPR_IDX_VR:       dat = spr_vr;
            SPR_IDX_UPR:      dat = spr_upr;
            SPR_IDX_CPUCFGR:  dat = spr_cpucfgr;
            SPR_IDX_DMMUCFGR: dat = spr_dmmucfgr;
            SPR_IDX_IMMUCFGR: dat = spr_immucfgr;
            SPR_IDX_DCCFGR:   dat = spr_dccfgr;
            SPR_IDX_ICCFGR:   dat = spr_iccfgr;
            SPR_IDX_DCFGR:    dat = spr_dcfgr;
            SPR_IDX_PCCFGR:   dat = spr_pccfgr;
            SPR_IDX_VR2:      dat = spr_vr2;
            SPR_IDX_AVR:      dat = spr_avr;
            default:          dat = 32'd0;
         endcase
      end
   end

endmodule

// File: rtl/mor1kx_cfgrs_spr_slave.sv
// SPR-bus slave answering reads of the read-only group-0 configuration SPRs
// with a fixed IDLE -> LOOKUP -> RESP -> HOLD handshake. Ack and data are
// registered; data is zero whenever ack is low.
// Optional build macro MOR1KX_CFGRS_WRITE_ERR_EN adds a sticky write-error
// flag and a saturating write-hit counter (cleared by a write to index 31).
module mor1kx_cfgrs_spr_slave
   import mor1kx_cfgrs_spr_slave_pkg::*;
#(
   parameter int OPTION_CFGRS_MAX_INDEX    = 10,
   parameter int OPTION_CFGRS_ACK_ON_WRITE = 1
)
(
   input  logic        clk,
   input  logic        rst,
   input  logic [15:0] spr_bus_addr_i,
   input  logic        spr_bus_we_i,
   input  logic        spr_bus_stb_i,
   input  logic [31:0] spr_bus_dat_i,
   output logic [31:0] spr_bus_dat_o,
   output logic        spr_bus_ack_o,
`ifdef MOR1KX_CFGRS_WRITE_ERR_EN
   output logic        spr_cfg_werr_o,
   output logic [7:0]  spr_cfg_werr_cnt_o,
`endif
   input  logic [31:0] spr_vr,
   input  logic [31:0] spr_vr2,
   input  logic [31:0] spr_upr,
   input  logic [31:0] spr_cpucfgr,
   input  logic [31:0] spr_dmmucfgr,
   input  logic [31:0] spr_immucfgr,
   input  logic [31:0] spr_dccfgr,
   input  logic [31:0] spr_iccfgr,
   input  logic [31:0] spr_dcfgr,
   input  logic [31:0] spr_pccfgr,
   input  logic [31:0] spr_avr
);

   localparam logic ACK_WRITES = (OPTION_CFGRS_ACK_ON_WRITE != 0);

   cfgrs_state_e state_r, state_next_s;
   logic [4:0]   idx_r, idx_next_s;
   logic         we_r, we_next_s;
   logic         ack_r, ack_next_s;
   logic [31:0]  dat_r, dat_next_s;
   logic [31:0]  sel_dat_s;
   logic         hit_s;

   // Write data carries no meaning for read-only registers
   logic unused_s;
   assign unused_s = ^spr_bus_dat_i;

   assign hit_s = spr_bus_stb_i
                  && (spr_bus_addr_i[SPR_GROUP_MSB:SPR_GROUP_LSB] == 5'd0)
                  && (spr_bus_addr_i[10:0] <= 11'd31);

   mor1kx_cfgrs_spr_sel #(
      .OPTION_CFGRS_MAX_INDEX (OPTION_CFGRS_MAX_INDEX)
   ) u_sel (
      .idx          (idx_r),
      .spr_vr       (spr_vr),
      .spr_vr2      (spr_vr2),
      .spr_upr      (spr_upr),
      .spr_cpucfgr  (spr_cpucfgr),
      .spr_dmmucfgr (spr_dmmucfgr),
      .spr_immucfgr (spr_immucfgr),
      .spr_dccfgr   (spr_dccfgr),
      .spr_iccfgr   (spr_iccfgr),
      .spr_dcfgr    (spr_dcfgr),
      .spr_pccfgr   (spr_pccfgr),
      .spr_avr      (spr_avr),
      .dat          (sel_dat_s)
   );

   // Next-state, capture and registered-response decode
   always_comb begin
      state_next_s = state_r;
      idx_next_s   = idx_r;
      we_next_s    = we_r;
      ack_next_s   = 1'b0;
      dat_next_s   = 32'd0;
      case (state_r)
         ST_IDLE: begin
            if (hit_s) begin
               idx_next_s   = spr_bus_addr_i[4:0];
               we_next_s    = spr_bus_we_i;
               state_next_s = ST_LOOKUP;
            end else begin
               state_next_s = ST_IDLE;
            end
         end
         ST_LOOKUP: begin
            if (!spr_bus_stb_i) begin
               // Master gave up before the response: no ack
               state_next_s = ST_IDLE;
            end else if (we_r) begin
               ack_next_s   = ACK_WRITES;
               state_next_s = ST_RESP;
            end else begin
               ack_next_s   = 1'b1;
               dat_next_s   = sel_dat_s;
               state_next_s = ST_RESP;
            end
         end
         ST_RESP: begin
            state_next_s = ST_HOLD;
         end
         ST_HOLD: begin
            // Strobe still held after ack must not start a second access
            if (!spr_bus_stb_i) begin
               state_next_s = ST_IDLE;
            end else begin
               state_next_s = ST_HOLD;
            end
         end
         default: begin
            state_next_s = ST_IDLE;
         end
      endcase
   end

   // FSM state, captured request and registered ack/data
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_r <= ST_IDLE;
         idx_r   <= 5'd0;
         we_r    <= 1'b0;
         ack_r   <= 1'b0;
         dat_r   <= 32'd0;
      end else begin
         state_r <= state_next_s;
         idx_r   <= idx_next_s;
         we_r    <= we_next_s;
         ack_r   <= ack_next_s;
         dat_r   <= dat_next_s;
      end
   end

   assign spr_bus_ack_o = ack_r;
   assign spr_bus_dat_o = dat_r;

`ifdef MOR1KX_CFGRS_WRITE_ERR_EN
   logic       werr_r;
   logic [7:0] werr_cnt_r;
   logic       write_hit_s;

   // A write hit is counted as it enters RESP, so the flag shows in that cycle
   assign write_hit_s = (state_r == ST_LOOKUP) && spr_bus_stb_i && we_r;

   // Sticky write-error flag and saturating write-hit counter
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         werr_r     <= 1'b0;
         werr_cnt_r <= 8'd0;
      end else if (write_hit_s) begin
         if (idx_r == SPR_IDX_WERR_CLR) begin
            werr_r     <= 1'b0;
            werr_cnt_r <= 8'd0;
         end else begin
            werr_r     <= 1'b1;
            werr_cnt_r <= (werr_cnt_r == 8'hFF) ? 8'hFF : (werr_cnt_r + 8'd1);
         end
      end else begin
         werr_r     <= werr_r;
         werr_cnt_r <= werr_cnt_r;
      end
   end

   assign spr_cfg_werr_o     = werr_r;
   assign spr_cfg_werr_cnt_o = werr_cnt_r;
`endif

endmodule

// File: tb/tb_mor1kx_cfgrs_spr_slave.sv
// Self-checking bench for mor1kx_cfgrs_spr_slave: directed vector table,
// hand-written abort/reset/counter sequences, and randomized accesses
// checked against a behavioural model of the slave.
module tb_mor1kx_cfgrs_spr_slave;

   localparam int ACK_ON_WRITE = 1;
   localparam int MAX_INDEX    = 10;

   logic        clk;
   logic        rst;
   logic [15:0] spr_bus_addr_i;
   logic        spr_bus_we_i;
   logic        spr_bus_stb_i;
   logic [31:0] spr_bus_dat_i;
   logic [31:0] spr_bus_dat_o;
   logic        spr_bus_ack_o;
`ifdef MOR1KX_CFGRS_WRITE_ERR_EN
   logic        spr_cfg_werr_o;
   logic [7:0]  spr_cfg_werr_cnt_o;
`endif
   logic [31:0] cfg [0:10];

   int checks = 0;
   int errors = 0;

   // model of the write-error bookkeeping
   logic       m_werr = 1'b0;
   logic [7:0] m_cnt  = 8'd0;

   mor1kx_cfgrs_spr_slave #(
      .OPTION_CFGRS_MAX_INDEX    (MAX_INDEX),
      .OPTION_CFGRS_ACK_ON_WRITE (ACK_ON_WRITE)
   ) dut (
      .clk                (clk),
      .rst                (rst),
      .spr_bus_addr_i     (spr_bus_addr_i),
      .spr_bus_we_i       (spr_bus_we_i),
      .spr_bus_stb_i      (spr_bus_stb_i),
      .spr_bus_dat_i      (spr_bus_dat_i),
      .spr_bus_dat_o      (spr_bus_dat_o),
      .spr_bus_ack_o      (spr_bus_ack_o),
`ifdef MOR1KX_CFGRS_WRITE_ERR_EN
      .spr_cfg_werr_o     (spr_cfg_werr_o),
      .spr_cfg_werr_cnt_o (spr_cfg_werr_cnt_o),
`endif
      .spr_vr             (cfg[0]),
      .spr_vr2            (cfg[9]),
      .spr_upr            (cfg[1]),
      .spr_cpucfgr        (cfg[2]),
      .spr_dmmucfgr       (cfg[3]),
      .spr_immucfgr       (cfg[4]),
      .spr_dccfgr         (cfg[5]),
      .spr_iccfgr         (cfg[6]),
      .spr_dcfgr          (cfg[7]),
      .spr_pccfgr         (cfg[8]),
      .spr_avr            (cfg[10])
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic check(input string nm, input logic [31:0] act, input logic [31:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s: got %h expected %h", nm, act, req);
      end
   endtask

   // Spec-level behaviour of one access: which requests are answered and with what
   function automatic void model(input logic [15:0] a, input logic w,
                                 output logic ea, output logic [31:0] ed);
      int idx;
      idx = int'(a[10:0]);
      ea = 1'b0;
      ed = 32'd0;
      if (a[15:11] == 5'd0 && idx <= 31) begin
         if (w) begin
            ea = (ACK_ON_WRITE != 0);
         end else begin
            ea = 1'b1;
            ed = (idx <= 10 && idx <= MAX_INDEX) ? cfg[idx] : 32'd0;
         end
      end
   endfunction

   task automatic check_werr(input string nm);
`ifdef MOR1KX_CFGRS_WRITE_ERR_EN
      check({nm, " werr"}, {31'd0, spr_cfg_werr_o}, {31'd0, m_werr});
      check({nm, " wcnt"}, {24'd0, spr_cfg_werr_cnt_o}, {24'd0, m_cnt});
`endif
   endtask

   // One access: stb held for 3+hold cycles, ack expected only in cycle 3
   task automatic run_access(input string nm, input logic [15:0] a, input logic w,
                             input logic [31:0] wd, input int hold,
                             input logic ea, input logic [31:0] ed);
      logic eack;
      @(posedge clk); #1;
      spr_bus_addr_i = a;
      spr_bus_we_i   = w;
      spr_bus_dat_i  = wd;
      spr_bus_stb_i  = 1'b1;
      for (int c = 1; c <= 3 + hold; c++) begin
         @(negedge clk);
         eack = (c == 3) && ea;
         check($sformatf("%s c%0d ack", nm, c), {31'd0, spr_bus_ack_o}, {31'd0, eack});
         check($sformatf("%s c%0d dat", nm, c), spr_bus_dat_o, eack ? ed : 32'd0);
         if (c == 2) begin
            // request changes after capture must not matter
            spr_bus_addr_i = a ^ 16'h0005;
            spr_bus_we_i   = ~w;
         end
      end
      @(posedge clk); #1;
      spr_bus_stb_i  = 1'b0;
      spr_bus_addr_i = 16'h0000;
      spr_bus_we_i   = 1'b0;
      if (w && a[15:11] == 5'd0 && a[10:0] <= 11'd31) begin
         if (a[4:0] == 5'd31) begin
            m_werr = 1'b0;
            m_cnt  = 8'd0;
         end else begin
            m_werr = 1'b1;
            m_cnt  = (m_cnt == 8'hFF) ? 8'hFF : m_cnt + 8'd1;
         end
      end
      @(negedge clk);
      check({nm, " after ack"}, {31'd0, spr_bus_ack_o}, 32'd0);
      check_werr(nm);
   endtask

   typedef struct {
      string       nm;
      logic [15:0] addr;
      logic        we;
      logic [31:0] wdat;
      int          hold;
      logic        exp_ack;
      logic [31:0] exp_dat;
   } vec_t;

   vec_t vecs[$];

   initial begin
      logic        ea;
      logic [31:0] ed;
      logic [15:0] ra;
      logic        rw;

      vecs.push_back('{"rd_cpucfgr", 16'h0002, 1'b0, 32'h0, 1, 1'b1, 32'h0000_0F20});
      vecs.push_back('{"grp1",       16'h0800, 1'b0, 32'h0, 7, 1'b0, 32'h0});
      vecs.push_back('{"idx64",      16'h0040, 1'b0, 32'h0, 7, 1'b0, 32'h0});
      vecs.push_back('{"rd_avr_hold",16'h000A, 1'b0, 32'h0, 6, 1'b1, 32'h0101_0000});
      vecs.push_back('{"wr_cpucfgr", 16'h0002, 1'b1, 32'hFFFF_FFFF, 1, 1'b1, 32'h0});
      vecs.push_back('{"rd_vr",      16'h0000, 1'b0, 32'h0, 1, 1'b1, 32'h1200_0009});
      vecs.push_back('{"rd_upr",     16'h0001, 1'b0, 32'h0, 1, 1'b1, 32'h0000_0705});
      vecs.push_back('{"rd_dmmu",    16'h0003, 1'b0, 32'h0, 1, 1'b1, 32'h0000_1C1B});
      vecs.push_back('{"rd_immu",    16'h0004, 1'b0, 32'h0, 1, 1'b1, 32'h0000_1C1A});
      vecs.push_back('{"rd_dccfgr",  16'h0005, 1'b0, 32'h0, 1, 1'b1, 32'h0000_00A5});
      vecs.push_back('{"rd_iccfgr",  16'h0006, 1'b0, 32'h0, 1, 1'b1, 32'h0000_00B4});
      vecs.push_back('{"rd_dcfgr",   16'h0007, 1'b0, 32'h0, 1, 1'b1, 32'h0000_0401});
      vecs.push_back('{"rd_pccfgr",  16'h0008, 1'b0, 32'h0, 1, 1'b1, 32'h0000_0007});
      vecs.push_back('{"rd_vr2",     16'h0009, 1'b0, 32'h0, 2, 1'b1, 32'h5000_0001});
      vecs.push_back('{"rd_idx11",   16'h000B, 1'b0, 32'h0, 1, 1'b1, 32'h0});
      vecs.push_back('{"rd_idx31",   16'h001F, 1'b0, 32'h0, 1, 1'b1, 32'h0});
      vecs.push_back('{"idx32",      16'h0020, 1'b0, 32'h0, 2, 1'b0, 32'h0});
      vecs.push_back('{"grp31",      16'hF802, 1'b0, 32'h0, 2, 1'b0, 32'h0});
      vecs.push_back('{"rd_cpu_again",16'h0002,1'b0, 32'h0, 1, 1'b1, 32'h0000_0F20});

      cfg[0]  = 32'h1200_0009; cfg[1]  = 32'h0000_0705; cfg[2]  = 32'h0000_0F20;
      cfg[3]  = 32'h0000_1C1B; cfg[4]  = 32'h0000_1C1A; cfg[5]  = 32'h0000_00A5;
      cfg[6]  = 32'h0000_00B4; cfg[7]  = 32'h0000_0401; cfg[8]  = 32'h0000_0007;
      cfg[9]  = 32'h5000_0001; cfg[10] = 32'h0101_0000;

      spr_bus_addr_i = 16'h0000;
      spr_bus_we_i   = 1'b0;
      spr_bus_stb_i  = 1'b0;
      spr_bus_dat_i  = 32'h0;
      rst = 1'b1;
      #2;
      check("reset ack", {31'd0, spr_bus_ack_o}, 32'd0);
      check("reset dat", spr_bus_dat_o, 32'd0);
      check_werr("reset");
      repeat (2) @(posedge clk);
      @(negedge clk);
      rst = 1'b0;

      // directed table
      foreach (vecs[i])
         run_access(vecs[i].nm, vecs[i].addr, vecs[i].we, vecs[i].wdat,
                    vecs[i].hold, vecs[i].exp_ack, vecs[i].exp_dat);

      // abort: stb dropped while the slave is in LOOKUP
      @(posedge clk); #1;
      spr_bus_addr_i = 16'h0005;
      spr_bus_we_i   = 1'b0;
      spr_bus_stb_i  = 1'b1;
      @(negedge clk);
      check("abort c1 ack", {31'd0, spr_bus_ack_o}, 32'd0);
      @(posedge clk); #1;
      spr_bus_stb_i = 1'b0;
      @(negedge clk);
      check("abort c2 ack", {31'd0, spr_bus_ack_o}, 32'd0);
      @(negedge clk);
      check("abort c3 ack", {31'd0, spr_bus_ack_o}, 32'd0);
      check("abort c3 dat", spr_bus_dat_o, 32'd0);
      run_access("rd_vr_after_abort", 16'h0000, 1'b0, 32'h0, 1, 1'b1, 32'h1200_0009);

      // write counter saturation and clear slot
      for (int i = 0; i < 300; i++)
         run_access("wr_burst", 16'h0002, 1'b1, 32'hFFFF_FFFF, 1, 1'b1, 32'h0);
`ifdef MOR1KX_CFGRS_WRITE_ERR_EN
      check("wcnt saturated", {24'd0, spr_cfg_werr_cnt_o}, 32'h0000_00FF);
      check("werr set", {31'd0, spr_cfg_werr_o}, 32'd1);
`endif
      run_access("wr_clear", 16'h001F, 1'b1, 32'h0, 1, 1'b1, 32'h0);
`ifdef MOR1KX_CFGRS_WRITE_ERR_EN
      check("wcnt cleared", {24'd0, spr_cfg_werr_cnt_o}, 32'd0);
      check("werr cleared", {31'd0, spr_cfg_werr_o}, 32'd0);
`endif
      run_access("wr_after_clear", 16'h0004, 1'b1, 32'h1234, 1, 1'b1, 32'h0);
      check_werr("wr_after_clear");

      // reset asserted in the RESP cycle drops ack without a clock edge
      @(posedge clk); #1;
      spr_bus_addr_i = 16'h0005;
      spr_bus_we_i   = 1'b0;
      spr_bus_stb_i  = 1'b1;
      @(posedge clk);
      @(posedge clk);
      @(negedge clk);
      check("pre-rst ack", {31'd0, spr_bus_ack_o}, 32'd1);
      check("pre-rst dat", spr_bus_dat_o, 32'h0000_00A5);
      #1 rst = 1'b1;
      #1;
      check("async rst ack", {31'd0, spr_bus_ack_o}, 32'd0);
      check("async rst dat", spr_bus_dat_o, 32'd0);
      m_werr = 1'b0;
      m_cnt  = 8'd0;
      check_werr("async rst");
      spr_bus_stb_i  = 1'b0;
      spr_bus_addr_i = 16'h0000;
      @(posedge clk);
      @(negedge clk);
      rst = 1'b0;
      run_access("rd_vr2_post_rst", 16'h0009, 1'b0, 32'h0, 1, 1'b1, 32'h5000_0001);

      // randomized accesses against the model
      for (int k = 0; k < 11; k++) cfg[k] = $urandom;
      for (int n = 0; n < 60; n++) begin
         if ($urandom_range(0, 9) < 7)
            ra = {5'd0, 11'($urandom_range(0, 40))};
         else if ($urandom_range(0, 1) == 0)
            ra = {5'($urandom_range(1, 31)), 11'($urandom_range(0, 31))};
         else
            ra = {5'd0, 11'($urandom_range(32, 2047))};
         rw = ($urandom_range(0, 3) == 0);
         if (n == 30) for (int k = 0; k < 11; k++) cfg[k] = $urandom;
         model(ra, rw, ea, ed);
         run_access($sformatf("rand%0d_%h", n, ra), ra, rw, $urandom,
                    $urandom_range(1, 3), ea, ed);
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/mor1kx_cfgrs_spr_slave.md
Name: mor1kx_cfgrs_spr_slave

Overview:
- SPR-bus slave for the read-only configuration/version SPRs in group 0: VR, UPR, CPUCFGR, DMMUCFGR, IMMUCFGR, DCCFGR, ICCFGR, DCFGR, PCCFGR, VR2 and AVR.
- Sits directly downstream of the configuration-register block: consumes its eleven 32-bit constant outputs and answers SPR bus accesses from the CPU control stage with a registered, handshaked response.
- Takes this decode out of the main SPR mux so that group-0 config reads cost one fixed pipeline and never touch timing-critical paths.

Parameters:
- OPTION_CFGRS_MAX_INDEX, 10, highest group-0 index this slave claims. Valid range 10..31. Higher indices in the claimed window read as zero.
- OPTION_CFGRS_ACK_ON_WRITE, 1, 1 = acknowledge writes and discard the data; 0 = do not acknowledge writes, so they are left to the bus timeout.

Ports:
- clk  in  1  core clock
- rst  in  1  asynchronous, active-high reset
- spr_bus_addr_i  in  16  SPR address: {group[15:11], index[10:0]}
- spr_bus_we_i  in  1  write enable
- spr_bus_stb_i  in  1  access strobe; level, held until ack is seen
- spr_bus_dat_i  in  32  write data (ignored)
- spr_bus_dat_o  out  32  read data, valid while ack is high
- spr_bus_ack_o  out  1  single-cycle acknowledge
- spr_vr, spr_vr2, spr_upr, spr_cpucfgr, spr_dmmucfgr, spr_immucfgr, spr_dccfgr, spr_iccfgr, spr_dcfgr, spr_pccfgr, spr_avr  in  32 each  configuration values

Behaviour:
- Clocking and reset: one clock domain, clk. rst is asynchronous and active-high.
- Reset values: state = IDLE, spr_bus_ack_o = 0, spr_bus_dat_o = 0, internal address and index registers = 0.
- Hit: spr_bus_stb_i && addr[15:11]==0 && addr[10:0] <= 31.
  - Indices outside 0..31 and all other groups are ignored: no ack, data stays 0.
- FSM states:
  - IDLE: on hit, capture addr[4:0] and we, then go to LOOKUP.
  - LOOKUP: select data by index: 0 VR, 1 UPR, 2 CPUCFGR, 3 DMMUCFGR, 4 IMMUCFGR, 5 DCCFGR, 6 ICCFGR, 7 DCFGR, 8 PCCFGR, 9 VR2, 10 AVR, all other indices 0. Register the selected value into spr_bus_dat_o.
    - If stb has dropped (abort), return to IDLE with no ack and clear data to 0.
    - Otherwise go to RESP.
  - RESP: spr_bus_ack_o = 1 for exactly one cycle, then go to HOLD.
    - Write with OPTION_CFGRS_ACK_ON_WRITE=0: no ack, data 0; go to HOLD.
  - HOLD: ack = 0 and data = 0. Wait for spr_bus_stb_i == 0, then go to IDLE.
    - This prevents a re-trigger on a strobe that is still held after ack.
- Latency: ack is asserted 2 cycles after the first cycle stb is sampled high in IDLE.
  - Minimum issue interval is 4 cycles: IDLE, LOOKUP, RESP, HOLD with stb low.
- Address or we changing after capture: ignored. The captured values are used.
- Writes with OPTION_CFGRS_ACK_ON_WRITE=1: acknowledged, spr_bus_dat_o = 0, no state change, all config values unaffected.
- Config inputs are sampled only in LOOKUP. They are treated as quasi-static, so no synchronisation is needed.
- Reset asserted in any state: immediate return to IDLE; ack and data drop asynchronously. A pending access gets no ack.
- spr_bus_dat_o is 0 in every cycle where ack is low.

Optional Feature:
- Macro: MOR1KX_CFGRS_WRITE_ERR_EN.
- Enabled:
  - Adds output spr_cfg_werr_o (1 bit): sticky flag, set in the RESP cycle of any write hit.
  - Adds output spr_cfg_werr_cnt_o (8 bits): write-hit count, saturating at 8'hFF.
  - Both outputs reset to 0 on rst only.
  - A write to index 31 (reserved clear slot) clears both outputs instead of counting. The write is still acknowledged per OPTION_CFGRS_ACK_ON_WRITE.
- Disabled: the ports are absent and writes are silently discarded as above.

Decomposition:
- Shared package/defines file:
  - SPR group-0 index constants 0..10.
  - Group field position [15:11].
  - FSM state encoding: IDLE=2'd0, LOOKUP=2'd1, RESP=2'd2, HOLD=2'd3.
- Index constants live next to the existing OR1K SPR definitions.
- One natural sub-module: mor1kx_cfgrs_spr_sel. It is the combinational 5-bit index to 32-bit value selector, with OPTION_CFGRS_MAX_INDEX masking.
- The FSM and output registers stay in the top level.

Test Plan:
- Reset, then read addr 16'h0002 with spr_cpucfgr=32'h0000_0F20 → ack high in cycle 3 only, dat=32'h0000_0F20, dat=0 in all other cycles.
- Read addr 16'h0800 (group 1) and 16'h0040 (index 64) held high 10 cycles → no ack, dat stays 0, FSM stays IDLE.
- Read index 10 (AVR=32'h0101_0000), stb held 6 cycles after ack → exactly one ack pulse; next access accepted only after stb low.
- Read index 5, drop stb in the LOOKUP cycle → no ack; immediately following read of index 0 returns spr_vr normally.
- Write index 2 with dat_i=32'hFFFF_FFFF, OPTION_CFGRS_ACK_ON_WRITE=1 → ack with dat=0.
  - With MOR1KX_CFGRS_WRITE_ERR_EN: werr=1, cnt=1.
  - After 300 further writes: cnt=8'hFF.
  - A write to index 31 clears both.
- Assert rst during RESP → ack deasserts in the same cycle without a clock edge; after release the FSM is IDLE and a new read of index 9 returns spr_vr2.
